// File: rtl/multu_pkg.sv
// Shared constants and types for the MULTU unit and its Hi/Lo register pair.
package multu_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HI   = 2'b01;
    localparam logic [1:0] SEL_LO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multu_state_t;

endpackage : multu_pkg

// File: rtl/hilo_reg.sv
// Architectural Hi/Lo pair: one write port (64-bit), combinational MFHI/MFLO read mux.
// Write takes effect on the enabled edge; read never stalls.
module hilo_reg
    import multu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]              sel_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_i) begin
            hi_q <= wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_q <= wdata_i[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        rdata_o = '0;
        case (sel_i)
            SEL_HI:  rdata_o = hi_q;
            SEL_LO:  rdata_o = lo_q;
            default: rdata_o = '0;
        endcase
    end

endmodule : hilo_reg

// File: rtl/multu_unit.sv
// Sequential unsigned shift-add multiplier: 1 launch edge + 32 RUN edges, then DONE until start drops.
// MULTU_ZERO_SKIP_EN: a zero operand commits Hi=Lo=0 on the launch edge and goes straight to DONE.
module multu_unit
    import multu_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter logic [5:0] FUNCT_MULTU = multu_pkg::FUNCT_MULTU
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            SignaltoMULTU,
    input  logic [DATA_WIDTH-1:0] dataA,
    input  logic [DATA_WIDTH-1:0] dataB,
    input  logic [1:0]            SelHilo,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    multu_state_t            state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic [DATA_WIDTH-1:0]   mcand_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    start;
    logic                    zero_skip;
    logic                    last_iter;
    logic [DATA_WIDTH:0]     sum_d;
    logic [2*DATA_WIDTH-1:0] prod_d;
    logic                    hilo_we;
    logic [2*DATA_WIDTH-1:0] hilo_wdata;

    assign start = (SignaltoMULTU == FUNCT_MULTU);

`ifdef MULTU_ZERO_SKIP_EN
    assign zero_skip = (dataA == '0) || (dataB == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // One iteration: the 33-bit sum keeps the carry that becomes product bit 63 after the shift.
    always_comb begin
        sum_d  = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mcand_q};
        prod_d = prod_q >> 1;
        if (prod_q[0]) begin
            prod_d = {sum_d, prod_q[DATA_WIDTH-1:1]};
        end
    end

    assign last_iter  = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign hilo_we    = last_iter || ((state_q == IDLE) && start && zero_skip);
    assign hilo_wdata = last_iter ? prod_d : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (zero_skip) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            mcand_q <= dataA;
                            prod_q  <= {{DATA_WIDTH{1'b0}}, dataB};
                            cnt_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // Level re-arm: a held start must not launch a second multiply.
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    hilo_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hilo (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (hilo_we),
        .wdata_i (hilo_wdata),
        .sel_i   (SelHilo),
        .rdata_o (dataOut)
    );

endmodule : multu_unit

// File: tb/tb_multu_unit.sv
// Bench for multu_unit: cycle model of Hi/Lo/busy/done checked every negedge, plus directed literal checks.
module tb_multu_unit;

    localparam logic [5:0] START = 6'b011001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  SignaltoMULTU = 6'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic [1:0]  SelHilo = 2'b01;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    multu_unit dut (
        .clk           (clk),
        .rst           (rst),
        .SignaltoMULTU (SignaltoMULTU),
        .dataA         (dataA),
        .dataB         (dataB),
        .SelHilo       (SelHilo),
        .dataOut       (dataOut),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: full 64-bit product at launch, committed after a 32-cycle countdown.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
                m_done = 1'b1;
            end
        end else if (m_done) begin
            if (SignaltoMULTU != START) m_done = 1'b0;
        end else if (SignaltoMULTU == START) begin
            m_pend = {32'd0, dataA} * {32'd0, dataB};
`ifdef MULTU_ZERO_SKIP_EN
            if (dataA == 32'd0 || dataB == 32'd0) begin
                m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b1;
            end else begin
                m_left = 32;
            end
`else
            m_left = 32;
`endif
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (SelHilo == 2'b01) ? m_hi : (SelHilo == 2'b10) ? m_lo : 32'd0;
        chk("model dataOut", {32'd0, dataOut}, {32'd0, exp_out});
        chk("model busy", {63'd0, busy}, {63'd0, (m_left > 0)});
        chk("model done", {63'd0, done}, {63'd0, m_done});
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        SignaltoMULTU = START; dataA = a; dataB = b;
        @(posedge clk); #1;
        SignaltoMULTU = 6'd0;
    endtask

    task automatic run_until_done(input int exp_busy, input string name);
        int n = 0;
        int nb = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) nb++;
        end
        chk({name, " done"}, {63'd0, done}, 64'd1);
        chk({name, " busy cycles"}, 64'(nb), 64'(exp_busy));
    endtask

    task automatic read_chk(input logic [1:0] sel, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        SelHilo = sel;
        @(negedge clk);
        chk(name, {32'd0, dataOut}, {32'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", {32'd0, dataOut}, 64'd0);
        SelHilo = 2'b10;
        #1;
        chk("reset lo", {32'd0, dataOut}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 3 x 5
        launch(32'd3, 32'd5);
        run_until_done(32, "3x5");
        read_chk(2'b01, 32'h0000_0000, "3x5 hi");
        read_chk(2'b10, 32'h0000_000F, "3x5 lo");
        read_chk(2'b00, 32'h0, "sel 00");
        read_chk(2'b11, 32'h0, "sel 11");

        // Max operands: carry into bit 63
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_until_done(32, "max");
        read_chk(2'b01, 32'hFFFF_FFFE, "max hi");
        read_chk(2'b10, 32'h0000_0001, "max lo");

        // Start held for 50 edges: exactly one multiply
        @(posedge clk); #1;
        SignaltoMULTU = START; dataA = 32'h0001_0000; dataB = 32'h0001_0000;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        chk("held busy cycles", 64'(n), 64'd32);
        chk("held done", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        SignaltoMULTU = 6'd0;
        @(negedge clk);
        chk("held still done", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("held idle", {63'd0, done}, 64'd0);
        read_chk(2'b01, 32'h0000_0001, "held hi");
        read_chk(2'b10, 32'h0000_0000, "held lo");

        // Reset mid-RUN after a 7 x 6 result
        launch(32'd7, 32'd6);
        run_until_done(32, "7x6");
        read_chk(2'b10, 32'd42, "7x6 lo");
        launch(32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst lo", {32'd0, dataOut}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post-rst busy", {63'd0, busy}, 64'd0);
        chk("post-rst done", {63'd0, done}, 64'd0);
        chk("post-rst lo", {32'd0, dataOut}, 64'd0);

        // Old Lo visible throughout RUN, operand changes ignored
        launch(32'd7, 32'd6);
        run_until_done(32, "7x6 again");
        launch(32'd2, 32'd2);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (done !== 1'b1) chk("lo during run", {32'd0, dataOut}, 64'd42);
            if (n == 5) begin
                dataA = 32'd100;
                dataB = 32'd100;
            end
        end
        chk("2x2 done", {63'd0, done}, 64'd1);
        chk("2x2 lo", {32'd0, dataOut}, 64'd4);

        // Zero operand
        launch(32'd0, 32'd9);
`ifdef MULTU_ZERO_SKIP_EN
        run_until_done(0, "0x9");
`else
        run_until_done(32, "0x9");
`endif
        read_chk(2'b10, 32'd0, "0x9 lo");
        read_chk(2'b01, 32'd0, "0x9 hi");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multu_unit

// File: doc/multu_unit.md
# multu_unit

Sequential 32-bit unsigned shift-add multiplier with the architectural Hi/Lo register pair. Sits directly downstream of the ALU control unit. Consumes its `SignaltoMULTU` start code and `SelHilo` read select. Takes rs/rt operands from the register file and returns the MFHI/MFLO read value to the write-back mux.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand width; Hi and Lo are each `DATA_WIDTH` bits.
- `FUNCT_MULTU`, 6'b011001: start code on `SignaltoMULTU`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `SignaltoMULTU` in 6: start request when equal to `FUNCT_MULTU`; any other value means no request.
- `dataA` in DATA_WIDTH: multiplicand (rs).
- `dataB` in DATA_WIDTH: multiplier (rt).
- `SelHilo` in 2: read select. 01 selects Hi, 10 selects Lo, 00/11 output 0.
- `dataOut` out DATA_WIDTH: combinational read of the committed Hi/Lo.
- `busy` out 1: multiply in progress.
- `done` out 1: result committed; waiting for the start request to drop.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE to RUN when `start = (SignaltoMULTU == FUNCT_MULTU)` at a rising edge.
  - Latch `dataA` into the multiplicand register.
  - Load product = {32'b0, `dataB`}.
  - Clear counter.
- RUN, every edge:
  - If product[0] = 1, product[63:31] = {1'b0, product[63:32]} + multiplicand, a 33-bit add so the carry is kept.
  - Otherwise, product = product >> 1.
  - Counter increments.
- On the iteration with counter == 31:
  - Write Hi = final[63:32] and Lo = final[31:0].
  - Go to DONE.
- DONE:
  - Hold while start is asserted. Re-arm is level based: one MULTU instruction gives exactly one multiply.
  - Go to IDLE on the first edge with start deasserted.
- Start in RUN or DONE is ignored. Operand changes after the launch edge are ignored.
- Hi/Lo change only on the commit edge. Reads during RUN return the previous result.
- `busy` = (state == RUN). `done` = (state == DONE). Both are registered-state decodes and glitch-free.
- Reset values, applied asynchronously at any time including mid-RUN:
  - state IDLE, counter 0, product 0, multiplicand 0.
  - Hi 0, Lo 0.
  - `busy` 0, `done` 0, `dataOut` 0.
  - An interrupted multiply is discarded.

## Timing
- E0 (IDLE, start=1): launch.
- E1 to E32: 32 iterations. E32 commits Hi/Lo and enters DONE.
- `busy` is high for exactly 32 cycles, after E0 through E32.
- `dataOut` shows the new result in the cycle after E32.
- Minimum issue interval is 34 cycles: 32 RUN cycles, at least 1 DONE cycle, and 1 IDLE cycle with start low.
- Back-to-back MULTU needs start to drop for at least one edge in between.
- Simultaneous events:
  - Commit edge vs read: the read sees the old value until after the edge.
  - Reset at the commit edge: reset wins and Hi/Lo = 0.

## Configuration
- `MULTU_ZERO_SKIP_EN` defined:
  - At launch, if `dataA` == 0 or `dataB` == 0, write Hi = Lo = 0 on E0 and go straight IDLE to DONE.
  - `busy` never rises for that request. Latency is 1 edge.
- `MULTU_ZERO_SKIP_EN` not defined: every multiply takes 32 RUN cycles.
- Result values are identical either way.

## Structure
- Shared package `multu_pkg` holds:
  - `FUNCT_MULTU`, `FUNCT_MFHI` (6'b010000) and `FUNCT_MFLO` (6'b010010).
  - The `SelHilo` encodings (SEL_NONE 00, SEL_HI 01, SEL_LO 10).
  - The state enum `multu_state_t` {IDLE, RUN, DONE}.
- Sub-module `hilo_reg` contains:
  - the Hi/Lo register pair, with async reset and a single write enable plus 64-bit write data;
  - the `SelHilo` read mux that drives `dataOut`.
- The top level contains the FSM, counter and datapath.

## Test plan
- Reset then SelHilo=01 and SelHilo=10: `dataOut`=0, `busy`=0, `done`=0.
- 3 × 5, start for 1 cycle:
  - `busy` high for 32 cycles, then `done`.
  - Hi=0x00000000, Lo=0x0000000F.
- 0xFFFFFFFF × 0xFFFFFFFF: Hi=0xFFFFFFFE, Lo=0x00000001. This checks the carry into bit 63.
- Start held 50 cycles on 0x10000 × 0x10000:
  - Single multiply; DONE held until start drops, then IDLE next edge.
  - Hi=0x00000001, Lo=0.
- Reset asserted 10 cycles into RUN after a prior 7 × 6 result: immediately IDLE, Hi=Lo=0, `busy`=0, and no commit follows.
- Prior result 42 in Lo, new 2 × 2 launched:
  - Lo reads 42 throughout RUN, even with `dataA`/`dataB` changed mid-RUN.
  - Lo reads 4 after commit.
  - With `MULTU_ZERO_SKIP_EN`, 0 × 9 reaches DONE after 1 edge.
